dyn_output_arbiter: RTL and testbench

- Per-output-port wormhole arbiter for the dynamic network router.
- Sits directly upstream of the 8:1 crossbar output mux and drives that mux's 3-bit select.
- Chooses one of eight input FIFOs by round-robin and locks the route until the whole packet has passed.
- Generates the pop (ack) back to the winning input FIFO and the valid to the downstream output buffer.

---
 rtl/dyn_output_arbiter.sv | 142 ++++++++++++++
 tb/tb_dyn_output_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_output_arbiter.sv
// dyn_output_arbiter
// Wormhole arbiter for one output port of the dynamic network router. It sits
// directly upstream of the 8:1 crossbar output mux. It picks one of eight
// input FIFOs by round-robin and holds the route until the whole packet has
// passed. It pops the winning FIFO and flags valid flits to the output buffer.
//
// Optional feature: define DYN_ARB_WATCHDOG_EN to build the stall watchdog.
// Without it, stall_err is constant 0 and no counter exists.
//
// Parameters
//   LEN_W     width of the head-flit length field (body flits after the head)
//   WD_LIMIT  watchdog stall-cycle threshold (watchdog builds only)
//
// Ports
//   clk        router clock
//   reset      synchronous, active-high reset
//   req_in     per-input "head of FIFO targets this output" valid
//   len_in     per-input head-flit length, slice i = [i*LEN_W +: LEN_W]
//   out_ready  downstream output buffer accepts a flit this cycle
//   sel        crossbar select for the output mux
//   out_valid  flit on the mux output is valid
//   ack_out    one-hot pop to the selected input FIFO
//   busy       route is locked
//   stall_err  sticky watchdog error
module dyn_output_arbiter #(
  parameter int LEN_W    = 8,
  parameter int WD_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         req_in,
  input  logic [8*LEN_W-1:0] len_in,
  input  logic               out_ready,
  output logic [2:0]         sel,
  output logic               out_valid,
  output logic [7:0]         ack_out,
  output logic               busy,
  output logic               stall_err
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [2:0]        winner;
  logic [LEN_W-1:0]  win_len;
  logic              xfer;

  // Round-robin pick. The request vector is doubled and then rotated down by
  // ptr, so the lowest set bit is the nearest requester at or above ptr. The
  // wrap from 7 to 0 comes for free. The offset is added back modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr);
    logic [15:0] dbl;
    logic [2:0]  off;
    dbl = {req, req} >> ptr;
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dbl[i]) off = 3'(i);
    end
    return ptr + off;
  endfunction

  always_comb begin
    winner  = rr_pick(req_in, rr_ptr);
    win_len = '0;
    for (int i = 0; i < 8; i++) begin
      if (winner == 3'(i)) win_len = len_in[i*LEN_W +: LEN_W];
    end
    // Gated by reset so that no pop leaks out while the route is abandoned.
    out_valid = (state == XFER) && !reset && req_in[sel];
    xfer      = out_valid && out_ready;
    ack_out   = xfer ? (8'd1 << sel) : 8'd0;
  end

  assign busy = (state == XFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 3'd0;
      sel       <= 3'd0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_in) begin
            sel       <= winner;
            remaining <= win_len;
            state     <= XFER;
          end
        end
        XFER: begin
          // Bubbles and backpressure simply hold. Only the tail frees the route.
          if (xfer) begin
            if (remaining == '0) begin
              state  <= IDLE;
              rr_ptr <= sel + 3'd1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DYN_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT) + 1;

  logic [WD_W-1:0] stall_cnt;
  logic [WD_W-1:0] stall_cnt_nxt;

  // The counter saturates at the limit, so it cannot wrap while stuck.
  always_comb begin
    stall_cnt_nxt = (stall_cnt == WD_W'(WD_LIMIT)) ? stall_cnt
                                                   : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if ((state == XFER) && !xfer) begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == WD_W'(WD_LIMIT)) stall_err <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  logic wd_unused;
  assign wd_unused = (WD_LIMIT > 0);
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_dyn_output_arbiter.sv
// Directed bench for dyn_output_arbiter. An abstract packet model follows
// the owner, the flits left and the round-robin pointer. It is compared
// against the DUT every cycle. Literal expectations pin each scenario.
module tb_dyn_output_arbiter;
  localparam int LW = 8;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    req_in;
  logic [8*LW-1:0] len_in;
  logic          out_ready;
  logic [2:0]    sel;
  logic          out_valid;
  logic [7:0]    ack_out;
  logic          busy;
  logic          stall_err;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  dyn_output_arbiter #(.LEN_W(LW), .WD_LIMIT(WD)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .len_in(len_in),
    .out_ready(out_ready), .sel(sel), .out_valid(out_valid),
    .ack_out(ack_out), .busy(busy), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: packet-level view of the output port.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_left   = 0;   // flits still to move, including the current one
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_err    = 0;

  always @(negedge clk) begin
    if (run) begin
      bit e_valid;
      int e_ack;
      bit was_locked;
      e_valid = !reset && m_locked && req_in[m_owner];
      e_ack   = (e_valid && out_ready) ? (1 << m_owner) : 0;
      chk("sel", int'(sel), m_owner);
      chk("busy", int'(busy), int'(m_locked));
      chk("out_valid", int'(out_valid), int'(e_valid));
      chk("ack_out", int'(ack_out), e_ack);
`ifdef DYN_ARB_WATCHDOG_EN
      chk("stall_err", int'(stall_err), int'(m_err));
`else
      chk("stall_err", int'(stall_err), 0);
`endif
      was_locked = m_locked;
      if (reset) begin
        m_locked = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      end else begin
        if (!m_locked) begin
          for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (m_ptr + k) % 8;
            if (req_in[idx]) begin
              m_owner  = idx;
              m_left   = int'(len_in[idx*LW +: LW]) + 1;
              m_locked = 1;
              break;
            end
          end
        end else if (e_ack != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % 8;
          end
        end
        if (was_locked && e_ack == 0) begin
          if (m_cnt < WD) m_cnt++;
          if (m_cnt == WD) m_err = 1;
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len_in[i*LW +: LW] = LW'(v);
  endtask

  initial begin
    int grants[9];
    int ng;
    int acks;
    bit rdy_pat[5];
    reset = 1'b1; req_in = 8'h00; len_in = '0; out_ready = 1'b0;
    tick();
    run = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack_out), 0);
    chk("rst_err", int'(stall_err), 0);

    // Single packet, input 2, len 3.
    req_in = 8'h04; set_len(2, 3); out_ready = 1'b1;
    tick();
    chk("t1_busy", int'(busy), 1);
    chk("t1_sel", int'(sel), 2);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (ack_out == 8'h04) acks++;
      tick();
    end
    chk("t1_acks", acks, 4);
    chk("t1_release", int'(busy), 0);
    // Inputs 0 and 3 request. The pointer is now 3, so 3 must win.
    req_in = 8'h09; set_len(0, 0); set_len(3, 0);
    tick();
    chk("t1_ptr3", int'(sel), 3);
    tick();
    req_in = 8'h00;
    tick();

    // Round-robin order from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0; req_in = 8'hFF; len_in = '0; out_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 9; c++) begin
      if (ack_out != 8'h00) begin
        grants[ng] = int'(sel);
        ng++;
      end
      tick();
    end
    req_in = 8'h00;
    chk("t2_grants", ng, 9);
    for (int k = 0; k < 9; k++) chk("t2_order", (k < ng) ? grants[k] : -1, k % 8);

    // Backpressure on input 5, len 2.
    req_in = 8'h20; set_len(5, 2); out_ready = 1'b0;
    tick();
    chk("t3_sel", int'(sel), 5);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy_pat[c];
      #1;
      if (ack_out == 8'h20) acks++;
      tick();
    end
    chk("t3_acks", acks, 3);
    chk("t3_release", int'(busy), 0);
    req_in = 8'h00;
    tick();

    // Bubble mid-packet on input 1, len 3.
    req_in = 8'h02; set_len(1, 3); out_ready = 1'b1;
    tick();
    tick();
    req_in = 8'h00;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_valid", int'(out_valid), 0);
      chk("t4_ack", int'(ack_out), 0);
      chk("t4_busy", int'(busy), 1);
      chk("t4_sel", int'(sel), 1);
      tick();
    end
    req_in = 8'h02;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ack_out == 8'h02) acks++;
      tick();
    end
    chk("t4_acks", acks, 3);
    chk("t4_release", int'(busy), 0);
    req_in = 8'h00;
    tick();

    // Reset in the middle of a packet.
    req_in = 8'h01; set_len(0, 7); out_ready = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_ack", int'(ack_out), 0);
    tick();
    reset = 1'b0; req_in = 8'h00;
    #1;
    chk("t5_sel", int'(sel), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(out_valid), 0);
    req_in = 8'h40; set_len(6, 1);
    tick();
    chk("t5_grant6", int'(sel), 6);
    chk("t5_busy6", int'(busy), 1);
    tick();
    tick();
    chk("t5_release", int'(busy), 0);
    req_in = 8'h00;
    tick();

    // Long stall on input 0.
    req_in = 8'h01; set_len(0, 1); out_ready = 1'b0;
    tick();
    repeat (20) tick();
    out_ready = 1'b1;
    tick();
    tick();
    req_in = 8'h00;
    chk("t6_release", int'(busy), 0);
`ifdef DYN_ARB_WATCHDOG_EN
    chk("t6_stall_err", int'(stall_err), 1);
`else
    chk("t6_stall_err", int'(stall_err), 0);
`endif
    tick();
    tick();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
